// File: rtl/dsha_pkg.sv
// Shared widths, scheduler state encoding and the difficulty screen
// used by the dsha work scheduler and its result path.
package dsha_pkg;

    localparam int unsigned HASH_W  = 256;
    localparam int unsigned Y_W     = 96;
    localparam int unsigned NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

    // Hard target needs 32 leading zero bits; easy target only 24.
    function automatic logic meets_target(input logic [HASH_W-1:0] hash, input logic easy);
        return (hash[255:232] == '0) && (easy || (hash[231:224] == '0));
    endfunction

endpackage

// File: rtl/dsha_work_scheduler_result_fifo.sv
// Synchronous FIFO with flush; simultaneous push and pop are accepted even when full.
module result_fifo #(
    parameter int unsigned WIDTH = 288,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dsha_work_scheduler.sv
// Feeds work and a shared nonce counter to the finisher cores, screens their
// hashes against the target and queues round-robin-arbitrated winners.
module dsha_work_scheduler
    import dsha_pkg::*;
#(
    parameter int unsigned NUM_CORES  = 3,
    parameter int unsigned PIPE_DEPTH = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          work_valid,
    input  logic [HASH_W-1:0]             work_x,
    input  logic [Y_W-1:0]                work_y,
    input  logic [NONCE_W-1:0]            work_nonce_start,
    input  logic [NONCE_W-1:0]            work_nonce_end,
    input  logic                          easy_mode,
    output logic [HASH_W-1:0]             core_x,
    output logic [Y_W-1:0]                core_y,
    output logic [NONCE_W-1:0]            core_nonce,
    input  logic [NUM_CORES-1:0]          core_accepted,
    input  logic [NUM_CORES*HASH_W-1:0]   core_hash,
    input  logic [NUM_CORES*NONCE_W-1:0]  core_out_nonce,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [HASH_W-1:0]             res_hash,
    output logic [NONCE_W-1:0]            res_nonce,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    drop_count
);

    localparam int unsigned PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CNT_W    = $clog2(PIPE_DEPTH + 1);
    localparam logic [CNT_W-1:0] PIPE_CNT = CNT_W'(PIPE_DEPTH);
    localparam int unsigned RES_W    = HASH_W + NONCE_W;

    sched_state_t          state_q;
    sched_state_t          state_d;
    logic [NONCE_W-1:0]    end_q;
    logic [CNT_W-1:0]      blank_cnt;
    logic [CNT_W-1:0]      drain_cnt;
    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_CORES-1:0]  hit_raw;
    logic [NUM_CORES-1:0]  hit_q;
    logic [HASH_W-1:0]     hash_q  [NUM_CORES];
    logic [NONCE_W-1:0]    nonce_q [NUM_CORES];
    logic [NONCE_W-1:0]    last_nonce;
    logic                  last_valid;
    logic                  accept;
    logic                  last_accept;
    logic                  qualify;
    logic                  win_found;
    logic [PTR_W-1:0]      win_next_ptr;
    logic [HASH_W-1:0]     win_hash;
    logic [NONCE_W-1:0]    win_nonce;
    int unsigned           hit_cnt;
    int unsigned           drop_inc;
    int unsigned           drop_sum;
    logic [7:0]            drop_d;
    logic                  dup;
    logic                  push;
    logic                  overflow;
    logic                  pop_fire;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [RES_W-1:0]      fifo_dout;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (work_valid) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (last_accept) state_d = DRAIN;
                DRAIN:   if (drain_cnt <= CNT_W'(1)) state_d = DONE;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == DRAIN);
        done = (state_q == DONE);
    end

    assign accept      = (state_q == RUN) && (|core_accepted);
    assign last_accept = accept && (core_nonce == end_q);
    assign qualify     = ((state_q == RUN) || (state_q == DRAIN)) && (blank_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            core_x     <= '0;
            core_y     <= '0;
            core_nonce <= '0;
            end_q      <= '0;
            blank_cnt  <= '0;
            drain_cnt  <= '0;
        end else if (work_valid) begin
            core_x     <= work_x;
            core_y     <= work_y;
            core_nonce <= work_nonce_start;
            end_q      <= work_nonce_end;
            blank_cnt  <= PIPE_CNT;
            drain_cnt  <= '0;
        end else begin
            if (accept && !last_accept) core_nonce <= core_nonce + NONCE_W'(1);
            if (blank_cnt != '0) blank_cnt <= blank_cnt - CNT_W'(1);
            if (last_accept)
                drain_cnt <= PIPE_CNT;
            else if ((state_q == DRAIN) && (drain_cnt != '0))
                drain_cnt <= drain_cnt - CNT_W'(1);
        end
    end

    always_comb begin
        hit_raw = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++)
            hit_raw[i] = meets_target(core_hash[HASH_W*i +: HASH_W], easy_mode);
    end

    always_ff @(posedge clk) begin
        if (rst || work_valid) hit_q <= '0;
        else                   hit_q <= hit_raw & {NUM_CORES{qualify}};
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            hash_q[i]  <= core_hash[HASH_W*i +: HASH_W];
            nonce_q[i] <= core_out_nonce[NONCE_W*i +: NONCE_W];
        end
    end

    // Round robin: first pass covers indices at/after the pointer, second wraps below it.
    always_comb begin
        win_found    = 1'b0;
        win_hash     = '0;
        win_nonce    = '0;
        win_next_ptr = rr_ptr;
        hit_cnt      = 0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (hit_q[i]) hit_cnt = hit_cnt + 1;
            if (hit_q[i] && !win_found && (i >= 32'(rr_ptr))) begin
                win_found    = 1'b1;
                win_hash     = hash_q[i];
                win_nonce    = nonce_q[i];
                win_next_ptr = (i + 1 == NUM_CORES) ? '0 : PTR_W'(i + 1);
            end
        end
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (hit_q[i] && !win_found) begin
                win_found    = 1'b1;
                win_hash     = hash_q[i];
                win_nonce    = nonce_q[i];
                win_next_ptr = (i + 1 == NUM_CORES) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign pop_fire = res_valid && res_ready;
    assign dup      = last_valid && (win_nonce == last_nonce);
    assign push     = win_found && !dup && !work_valid && (!fifo_full || pop_fire);
    assign overflow = win_found && !dup && !work_valid && fifo_full && !pop_fire;

    always_comb begin
        drop_inc = 0;
        if (win_found && !work_valid) drop_inc = hit_cnt - 1 + {31'b0, overflow};
        drop_sum = 32'(drop_count) + drop_inc;
        drop_d   = (drop_sum > 255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            last_valid <= 1'b0;
            last_nonce <= '0;
            drop_count <= '0;
        end else begin
            drop_count <= drop_d;
            if (work_valid) begin
                last_valid <= 1'b0;
            end else begin
                if (win_found) rr_ptr <= win_next_ptr;
                if (push) begin
                    last_valid <= 1'b1;
                    last_nonce <= win_nonce;
                end
            end
        end
    end

    result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (work_valid),
        .push  (push),
        .pop   (pop_fire),
        .din   ({win_hash, win_nonce}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_hash  = res_valid ? fifo_dout[RES_W-1 -: HASH_W] : '0;
    assign res_nonce = res_valid ? fifo_dout[NONCE_W-1:0] : '0;

endmodule
